buttons: RTL
============

BUTTONS -- requirements
Module: buttons

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000, the number of consecutive stable samples needed to accept a level change (1 ms at 12 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 6000000, the hold time in cycles before the first auto-repeat (used only with BUTTONS_AUTOREPEAT_EN).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 1200000, the cycles between subsequent auto-repeats (used only with BUTTONS_AUTOREPEAT_EN).
REQ-004 clk  input  1  the single system clock; all logic is in this domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 SW1  input  1  raw push button (1 = pressed), asynchronous to clk; increments the value.
REQ-007 SW2  input  1  raw push button (1 = pressed), asynchronous to clk; decrements the value.
REQ-008 LED0..LED7  output  1 each  the current 8-bit value, with LED0 as the LSB.
REQ-009 SW1_PRESS, SW2_PRESS  output  1 each  one-cycle pulse on each accepted press or repeat event.

Function
REQ-010 Each SW input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have its own debounce FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, using a counter that is at least clog2(DEBOUNCE_CYCLES+1) bits wide.
REQ-012 IDLE SHALL go to PRESS_WAIT when the synchronized input is 1, clearing the counter.
REQ-013 PRESS_WAIT SHALL return to IDLE if the input drops to 0 before the count completes; after DEBOUNCE_CYCLES consecutive 1 samples it SHALL go to PRESSED and assert SWn_PRESS for exactly one cycle.
REQ-014 PRESSED SHALL go to RELEASE_WAIT when the input reads 0.
REQ-015 RELEASE_WAIT SHALL return to PRESSED if the input reads 1; after DEBOUNCE_CYCLES consecutive 0 samples it SHALL go to IDLE, with no pulse on release.
REQ-016 Latency from a clean edge on SWn to SWn_PRESS SHALL be 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse.
REQ-018 The 8-bit value SHALL increment on SW1_PRESS and decrement on SW2_PRESS, updating in the cycle after the pulse.
REQ-019 The value SHALL wrap modulo 256 (0xFF+1=0x00, 0x00-1=0xFF).
REQ-020 When SW1_PRESS and SW2_PRESS occur in the same cycle, the value SHALL remain unchanged.
REQ-021 LED0..LED7 SHALL be driven directly from registers, with no combinational path from SW1/SW2.

Reset
REQ-022 Asserting rst SHALL immediately and asynchronously clear the synchronizers, the FSMs (to IDLE), all counters, the value (LEDs = 0) and both PRESS outputs to 0.
REQ-023 Reset asserted mid-debounce or while a button is held SHALL discard the in-progress event.
REQ-024 After rst is released, a button still held SHALL be treated as a new press and debounced in full.

Configuration
REQ-025 With macro BUTTONS_AUTOREPEAT_EN defined, a button held in PRESSED for REPEAT_DELAY cycles after its press pulse SHALL emit another SWn_PRESS pulse, and then one pulse every REPEAT_PERIOD cycles until it leaves PRESSED.
REQ-026 Without BUTTONS_AUTOREPEAT_EN defined, there SHALL be no repeat logic; only one pulse is emitted per press, and REPEAT_DELAY and REPEAT_PERIOD are ignored.

Structure
REQ-027 Package buttons_pkg SHALL hold the debounce state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the VALUE_W=8 constant.
REQ-028 Sub-module debounce SHALL contain the synchronizer, the FSM, the counter and the optional repeat logic, and SHALL be instantiated twice; buttons holds the value register and the LED mapping.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 Reset check: assert rst with SW1 held -> LEDs=0x00 and no pulses while reset is asserted; after release, exactly one SW1_PRESS pulse 7 cycles later, giving LEDs=0x01.
REQ-030 Glitch check: SW1 high for 3 cycles, then low -> no pulse and LEDs unchanged; bounce of 1,0,1,0 followed by a steady 1 -> exactly one pulse.
REQ-031 Wrap check: preload LEDs=0xFF by 255 SW1 presses, then 1 more SW1 press -> 0x00; one SW2 press -> 0xFF.
REQ-032 Simultaneous check: SW1 and SW2 pressed on the same clock edge -> both pulses fire in the same cycle and the value is unchanged.
REQ-033 Auto-repeat check with BUTTONS_AUTOREPEAT_EN: hold SW1 for 60 cycles after its first pulse -> extra pulses at +20, +28, +36, +44, +52 and +60, giving LEDs=0x07; without the macro -> LEDs=0x01.
REQ-034 Reset mid-operation check: pulse rst during RELEASE_WAIT -> FSM returns to IDLE, LEDs=0x00, and no spurious pulse after release.

Source files
------------

// File: rtl/buttons_pkg.sv
// Shared types and constants for the two-button up/down counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package buttons_pkg;

    localparam int VALUE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

endpackage

// File: rtl/buttons_debounce.sv
// Per-button 2-flop synchronizer + debounce FSM; optional auto-repeat under BUTTONS_AUTOREPEAT_EN.
// Latency: press pulse 2 + DEBOUNCE_CYCLES + 1 cycles after a clean rising edge on sw.
// Backpressure: none; press is a one-cycle pulse that is never held or queued.
module debounce
    import buttons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Zero or negative timing parameters would make the terminal counts meaningless.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("debounce: timing parameters must be >= 1");
    end

    logic              sync_q1;
    logic              sw_s;
    db_state_t         state;
    logic [CNT_W-1:0]  cnt;

`ifdef BUTTONS_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]  rpt_cnt;
    logic              rpt_phase;   // 0: waiting for first repeat, 1: periodic repeats
`endif

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sw_s    <= sync_q1;
        end
    end

    // Debounce FSM: a level is accepted only after DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
`ifdef BUTTONS_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
`endif
        end else begin
            press <= 1'b0;
            case (state)
                IDLE: begin
                    if (sw_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sw_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        press <= 1'b1;
`ifdef BUTTONS_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sw_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef BUTTONS_AUTOREPEAT_EN
                    else if (rpt_cnt == (rpt_phase ? PER_LAST : DLY_LAST)) begin
                        press     <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (sw_s) begin
                        // Release bounce: back to held, repeat timing restarts from the full delay.
                        state <= PRESSED;
`ifdef BUTTONS_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/buttons.sv
// Two debounced buttons drive an 8-bit wrap-around up/down value shown on LED0..LED7.
// Latency: value changes one cycle after SW1_PRESS/SW2_PRESS; optional BUTTONS_AUTOREPEAT_EN adds hold-to-repeat.
// Backpressure: none; simultaneous up and down pulses cancel.
module buttons
    import buttons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic SW1,
    input  logic SW2,
    output logic LED0,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5,
    output logic LED6,
    output logic LED7,
    output logic SW1_PRESS,
    output logic SW2_PRESS
);

    logic [VALUE_W-1:0] value;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_sw1 (
        .clk   (clk),
        .rst   (rst),
        .sw    (SW1),
        .press (SW1_PRESS)
    );

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_sw2 (
        .clk   (clk),
        .rst   (rst),
        .sw    (SW2),
        .press (SW2_PRESS)
    );

    // Up/down value register; natural 8-bit wrap, coincident pulses leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (SW1_PRESS && !SW2_PRESS) begin
            value <= value + VALUE_W'(1);
        end else if (SW2_PRESS && !SW1_PRESS) begin
            value <= value - VALUE_W'(1);
        end
    end

    assign LED0 = value[0];
    assign LED1 = value[1];
    assign LED2 = value[2];
    assign LED3 = value[3];
    assign LED4 = value[4];
    assign LED5 = value[5];
    assign LED6 = value[6];
    assign LED7 = value[7];

endmodule
